// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: data width, cache geometry,
// FSM state encoding and a small address helper.
package icache_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int ICACHE_ADDR_BITS  = 18;
    localparam int ICACHE_INDEX_BITS = 7;
    localparam int ICACHE_TAG_WIDTH  = ICACHE_ADDR_BITS - 2 - ICACHE_INDEX_BITS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } icache_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the direct-mapped instruction cache: resettable valid bits plus
// tag and data arrays. The read port is asynchronous so a lookup and its hit
// decision complete within the cycle the request is sampled; the outputs of
// the cache are registered in the top level.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_WIDTH  = ICACHE_TAG_WIDTH,
    parameter int DWIDTH     = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_WIDTH-1:0]  o_rd_tag,
    output logic [DWIDTH-1:0]     o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_WIDTH-1:0]  i_wr_tag,
    input  logic [DWIDTH-1:0]     i_wr_data
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [DEPTH-1:0]     r_valid;
    logic [TAG_WIDTH-1:0] r_tag_mem  [DEPTH];
    logic [DWIDTH-1:0]    r_data_mem [DEPTH];

    // Valid bits: cleared by reset, set when a line is filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays: written on fill, never reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_wr_index]  <= i_wr_tag;
            r_data_mem[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag_mem[i_rd_index];
    assign o_rd_data  = r_data_mem[i_rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Serves hits one cycle
// after the request, fills misses with a single read from the memory unit,
// and drops outstanding work on rollback.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_BITS  = ICACHE_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_rollback,
    input  logic                  in_fetch_ena,
    input  logic [31:0]           in_fetch_addr,
    output logic                  out_fetch_ok,
    output logic [DATA_WIDTH-1:0] out_fetch_inst,
    output logic                  out_mem_ena,
    output logic [31:0]           out_mem_addr,
    input  logic                  in_mem_ok,
    input  logic [DATA_WIDTH-1:0] in_mem_data
);

    localparam int TAG_W = ADDR_BITS - 2 - INDEX_BITS;

    icache_state_e           r_state,      w_state_nxt;
    logic                    r_fetch_ok,   w_fetch_ok_nxt;
    logic [DATA_WIDTH-1:0]   r_fetch_inst, w_fetch_inst_nxt;
    logic                    r_mem_ena,    w_mem_ena_nxt;
    logic [31:0]             r_mem_addr,   w_mem_addr_nxt;
    logic [INDEX_BITS-1:0]   r_miss_index, w_miss_index_nxt;
    logic [TAG_W-1:0]        r_miss_tag,   w_miss_tag_nxt;

    logic [INDEX_BITS-1:0]   w_index;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_rd_valid;
    logic [TAG_W-1:0]        w_rd_tag;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_hit;
    logic                    w_wr_en;
    logic                    w_unused_addr;

    // Bits above ADDR_BITS-1 are deliberately left out of the tag: aliases
    // of the same physical word share a line.
    assign w_index       = in_fetch_addr[INDEX_BITS+1:2];
    assign w_tag         = in_fetch_addr[ADDR_BITS-1:INDEX_BITS+2];
    assign w_unused_addr = ^in_fetch_addr[1:0];
    assign w_hit         = w_rd_valid && (w_rd_tag == w_tag);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_WIDTH  (TAG_W),
        .DWIDTH     (DATA_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (r_miss_index),
        .i_wr_tag   (r_miss_tag),
        .i_wr_data  (in_mem_data)
    );

    // Next-state and output logic; ena=0 freezes everything, rollback wins
    // over any lookup or response but still lets a returning fill land.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_ok_nxt   = r_fetch_ok;
        w_fetch_inst_nxt = r_fetch_inst;
        w_mem_ena_nxt    = r_mem_ena;
        w_mem_addr_nxt   = r_mem_addr;
        w_miss_index_nxt = r_miss_index;
        w_miss_tag_nxt   = r_miss_tag;
        w_wr_en          = 1'b0;
        if (!ena) begin
            w_wr_en = 1'b0;
        end else if (in_rollback) begin
            w_state_nxt    = ST_IDLE;
            w_fetch_ok_nxt = 1'b0;
            w_mem_ena_nxt  = 1'b0;
            w_wr_en        = (r_state == ST_MISS) && in_mem_ok;
        end else begin
            w_fetch_ok_nxt = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_fetch_ena && !r_fetch_ok) begin
                        if (w_hit) begin
                            w_fetch_ok_nxt   = 1'b1;
                            w_fetch_inst_nxt = w_rd_data;
                        end else begin
                            w_state_nxt      = ST_MISS;
                            w_mem_ena_nxt    = 1'b1;
                            w_mem_addr_nxt   = word_align(in_fetch_addr);
                            w_miss_index_nxt = w_index;
                            w_miss_tag_nxt   = w_tag;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_MISS: begin
                    if (in_mem_ok) begin
                        w_wr_en          = 1'b1;
                        w_fetch_ok_nxt   = 1'b1;
                        w_fetch_inst_nxt = in_mem_data;
                        w_mem_ena_nxt    = 1'b0;
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_MISS;
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_mem_ena_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fetch_ok   <= 1'b0;
            r_fetch_inst <= {DATA_WIDTH{1'b0}};
            r_mem_ena    <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_miss_index <= {INDEX_BITS{1'b0}};
            r_miss_tag   <= {TAG_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_ok   <= w_fetch_ok_nxt;
            r_fetch_inst <= w_fetch_inst_nxt;
            r_mem_ena    <= w_mem_ena_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_miss_index <= w_miss_index_nxt;
            r_miss_tag   <= w_miss_tag_nxt;
        end
    end

    assign out_fetch_ok   = r_fetch_ok;
    assign out_fetch_inst = r_fetch_inst;
    assign out_mem_ena    = r_mem_ena;
    assign out_mem_addr   = r_mem_addr;

endmodule
